// File: rtl/fw_ip2_cfg_shift_ctrl_if.sv
// Memory-side buses of the config scan-chain sequencer: config array read port
// and readback array write port.
interface fw_ip2_cfg_shift_ctrl_if #(
   parameter int ADDR_W = 8
);
   logic [ADDR_W-1:0] cfg_rd_addr;
   logic [15:0]       cfg_rd_data;
   logic              rb_wr_en;
   logic [ADDR_W-1:0] rb_wr_addr;
   logic [15:0]       rb_wr_data;

   modport master (
      output cfg_rd_addr,
      input  cfg_rd_data,
      output rb_wr_en,
      output rb_wr_addr,
      output rb_wr_data
   );

   modport slave (
      input  cfg_rd_addr,
      output cfg_rd_data,
      input  rb_wr_en,
      input  rb_wr_addr,
      input  rb_wr_data
   );
endinterface

// File: rtl/fw_ip2_cfg_shift_ctrl.sv
// Config scan-chain sequencer: serializes config words LSB-first onto the DUT
// chain under a programmable shift clock and captures the chain output as readback.
module fw_ip2_cfg_shift_ctrl #(
   parameter int CFG_WORDS = 256,
   parameter int ADDR_W    = 8
) (
   input  logic                      fw_pl_clk1,
   input  logic                      op_code_w_reset,
   input  logic                      start,
   input  logic [11:0]               num_bits,
   input  logic [5:0]                half_period,
   fw_ip2_cfg_shift_ctrl_if.master   mem,
   output logic                      fw_config_clk,
   output logic                      fw_config_in,
   output logic                      fw_config_load,
   input  logic                      fw_config_out,
   output logic                      busy,
   output logic                      done,
   output logic [11:0]               bit_cnt
);

   localparam int MAX_BITS = CFG_WORDS * 16;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_SHIFT_LO,
      S_SHIFT_HI,
      S_LOAD_PULSE,
      S_DONE
   } state_e;

   state_e            state_q;
   logic [11:0]       n_q;
   logic [5:0]        hp_q;
   logic [6:0]        phase_q;
   logic [15:0]       word_q;
   logic [15:0]       rb_sh_q;
   logic [11:0]       bit_cnt_q;
   logic [ADDR_W-1:0] addr_q;
   logic              cfg_clk_q;
   logic              load_q;
   logic              busy_q;
   logic              done_q;
   logic              rb_wr_en_q;
   logic [ADDR_W-1:0] rb_wr_addr_q;
   logic [15:0]       rb_wr_data_q;

   logic [11:0]       n_d;
   logic [5:0]        hp_d;
   logic [12:0]       bit_next_d;
   logic [15:0]       rb_word_d;
   logic [6:0]        hp_last_d;
   logic [6:0]        lp_last_d;

   // NOTE: every variable gets a default at the top of always_comb, so no path leaves it unassigned and no latch is inferred.
   always_comb begin
      n_d        = (int'(num_bits) > MAX_BITS) ? 12'(MAX_BITS) : num_bits;
      hp_d       = (half_period == 6'd0) ? 6'd1 : half_period;
      bit_next_d = {1'b0, bit_cnt_q} + 13'd1;
      hp_last_d  = {1'b0, hp_q} - 7'd1;
      lp_last_d  = {hp_q, 1'b0} - 7'd1;
      rb_word_d  = rb_sh_q;
      rb_word_d[bit_cnt_q[3:0]] = fw_config_out;
   end

   // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
   always_ff @(posedge fw_pl_clk1) begin
      if (op_code_w_reset) begin
         state_q      <= S_IDLE;
         n_q          <= '0;
         hp_q         <= '0;
         phase_q      <= '0;
         word_q       <= '0;
         rb_sh_q      <= '0;
         bit_cnt_q    <= '0;
         addr_q       <= '0;
         cfg_clk_q    <= 1'b0;
         load_q       <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         rb_wr_en_q   <= 1'b0;
         rb_wr_addr_q <= '0;
         rb_wr_data_q <= '0;
      end else begin
         rb_wr_en_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  n_q       <= n_d;
                  hp_q      <= hp_d;
                  phase_q   <= '0;
                  word_q    <= '0;
                  rb_sh_q   <= '0;
                  bit_cnt_q <= '0;
                  addr_q    <= '0;
                  done_q    <= 1'b0;
                  busy_q    <= 1'b1;
                  state_q   <= (n_d == 12'd0) ? S_DONE : S_LOAD;
               end
            end
            S_LOAD: begin
               word_q  <= mem.cfg_rd_data;
               addr_q  <= addr_q + ADDR_W'(1);
               phase_q <= '0;
               state_q <= S_SHIFT_LO;
            end
            S_SHIFT_LO: begin
               if (phase_q == hp_last_d) begin
                  phase_q   <= '0;
                  cfg_clk_q <= 1'b1;
                  state_q   <= S_SHIFT_HI;
                  // A full word or the final (possibly partial) word goes out next cycle.
                  if (bit_cnt_q[3:0] == 4'hF || bit_next_d == {1'b0, n_q}) begin
                     rb_wr_en_q   <= 1'b1;
                     rb_wr_addr_q <= ADDR_W'(bit_cnt_q >> 4);
                     rb_wr_data_q <= rb_word_d;
                     rb_sh_q      <= '0;
                  end else begin
                     rb_sh_q <= rb_word_d;
                  end
               end else begin
                  phase_q <= phase_q + 7'd1;
               end
            end
            S_SHIFT_HI: begin
               if (phase_q == hp_last_d) begin
                  phase_q   <= '0;
                  cfg_clk_q <= 1'b0;
                  bit_cnt_q <= bit_next_d[11:0];
                  if (bit_next_d == {1'b0, n_q}) begin
                     word_q  <= '0;
                     load_q  <= 1'b1;
                     state_q <= S_LOAD_PULSE;
                  end else begin
                     word_q  <= {1'b0, word_q[15:1]};
                     state_q <= (bit_next_d[3:0] == 4'h0) ? S_LOAD : S_SHIFT_LO;
                  end
               end else begin
                  phase_q <= phase_q + 7'd1;
               end
            end
            S_LOAD_PULSE: begin
               if (phase_q == lp_last_d) begin
                  phase_q <= '0;
                  load_q  <= 1'b0;
                  state_q <= S_DONE;
               end else begin
                  phase_q <= phase_q + 7'd1;
               end
            end
            S_DONE: begin
               busy_q  <= 1'b0;
               done_q  <= 1'b1;
               state_q <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   // The word register is zeroed outside shifting, so its LSB is the serial data.
   assign fw_config_in    = word_q[0];
   assign fw_config_clk   = cfg_clk_q;
   assign fw_config_load  = load_q;
   assign busy            = busy_q;
   assign done            = done_q;
   assign bit_cnt         = bit_cnt_q;
   assign mem.cfg_rd_addr = addr_q;
   assign mem.rb_wr_en    = rb_wr_en_q;
   assign mem.rb_wr_addr  = rb_wr_addr_q;
   assign mem.rb_wr_data  = rb_wr_data_q;

endmodule

// File: tb/tb_fw_ip2_cfg_shift_ctrl.sv
// Directed bench for the config scan-chain sequencer; the DUT chain is a
// 16-bit shift register whose expected output stream the bench derives itself.
module tb_fw_ip2_cfg_shift_ctrl;
   localparam int CFG_WORDS = 256;
   localparam int ADDR_W    = 8;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [11:0] num_bits = '0;
   logic [5:0]  half_period = '0;
   logic        fw_config_clk, fw_config_in, fw_config_load, fw_config_out;
   logic        busy, done;
   logic [11:0] bit_cnt;

   fw_ip2_cfg_shift_ctrl_if #(.ADDR_W(ADDR_W)) mem_if ();
   logic [15:0] cfg_mem [CFG_WORDS];
   assign mem_if.cfg_rd_data = cfg_mem[mem_if.cfg_rd_addr];

   fw_ip2_cfg_shift_ctrl #(.CFG_WORDS(CFG_WORDS), .ADDR_W(ADDR_W)) dut (
      .fw_pl_clk1      (clk),
      .op_code_w_reset (rst),
      .start           (start),
      .num_bits        (num_bits),
      .half_period     (half_period),
      .mem             (mem_if),
      .fw_config_clk   (fw_config_clk),
      .fw_config_in    (fw_config_in),
      .fw_config_load  (fw_config_load),
      .fw_config_out   (fw_config_out),
      .busy            (busy),
      .done            (done),
      .bit_cnt         (bit_cnt)
   );

   always #5 clk = ~clk;

   // Chain model and output monitor, sampled on the falling edge.
   logic [15:0] chain_q = '0;
   logic [15:0] preload = '0;
   logic        chain_ld = 1'b0;
   logic        clk_prev = 1'b0, done_prev = 1'b0;
   int          clk_rises = 0, load_cycles = 0, busy_cycles = 0, done_rises = 0;
   logic        obs_bits[$];
   logic [23:0] obs_wr[$];
   assign fw_config_out = chain_q[0];

   always @(negedge clk) begin
      clk_prev  <= fw_config_clk;
      done_prev <= done;
      if (chain_ld) chain_q <= preload;
      else if (fw_config_clk && !clk_prev) chain_q <= {fw_config_in, chain_q[15:1]};
      if (fw_config_clk && !clk_prev) begin
         clk_rises <= clk_rises + 1;
         obs_bits.push_back(fw_config_in);
      end
      if (mem_if.rb_wr_en) obs_wr.push_back({mem_if.rb_wr_addr, mem_if.rb_wr_data});
      if (fw_config_load) load_cycles <= load_cycles + 1;
      if (busy) busy_cycles <= busy_cycles + 1;
      if (done && !done_prev) done_rises <= done_rises + 1;
   end

   int          vectors = 0, miscompares = 0;
   int          bit_base, wr_base, rise_base, load_base, busy_base, done_base;
   logic        exp_bits[$];
   logic [23:0] exp_wr[$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic cfg_bit(input int k);
      logic [15:0] w;
      w = cfg_mem[k / 16];
      return w[k % 16];
   endfunction

   // Chain output for bit k: the preload for the first 16 bits, then what was shifted in.
   function automatic logic out_bit(input int k, input logic [15:0] pre);
      return (k < 16) ? pre[k] : cfg_bit(k - 16);
   endfunction

   task automatic launch(input int n, input logic [5:0] hp, input logic [15:0] pre, input int hold);
      logic [15:0] data;
      preload  = pre;
      chain_ld = 1'b1;
      tick();
      chain_ld = 1'b0;
      for (int k = 0; k < n; k++) exp_bits.push_back(cfg_bit(k));
      for (int w = 0; w < (n + 15) / 16; w++) begin
         data = '0;
         for (int i = 0; i < 16; i++)
            if (w * 16 + i < n) data[i] = out_bit(w * 16 + i, pre);
         exp_wr.push_back({8'(w), data});
      end
      bit_base  = obs_bits.size();
      wr_base   = obs_wr.size();
      rise_base = clk_rises;
      load_base = load_cycles;
      busy_base = busy_cycles;
      done_base = done_rises;
      num_bits    = 12'(n);
      half_period = hp;
      start       = 1'b1;
      repeat (hold) tick();
      start = 1'b0;
   endtask

   task automatic wait_idle(input string tag, input int limit);
      for (int i = 0; i < limit; i++) begin
         if (!busy) break;
         @(negedge clk);
      end
      check({tag, " busy timeout"}, busy, 0);
      tick();
   endtask

   task automatic drain(input string tag, input int n_rises);
      int bi, wi, n_wr;
      logic        eb;
      logic [23:0] ew;
      check({tag, " clk rises"}, clk_rises - rise_base, n_rises);
      check({tag, " bits seen"}, obs_bits.size() - bit_base, exp_bits.size());
      bi = bit_base;
      while (exp_bits.size() > 0) begin
         eb = exp_bits.pop_front();
         if (bi < obs_bits.size()) check({tag, " config_in bit"}, obs_bits[bi], eb);
         bi++;
      end
      n_wr = exp_wr.size();
      check({tag, " rb writes"}, obs_wr.size() - wr_base, n_wr);
      wi = wr_base;
      while (exp_wr.size() > 0) begin
         ew = exp_wr.pop_front();
         if (wi < obs_wr.size()) check({tag, " rb addr/data"}, obs_wr[wi], ew);
         wi++;
      end
   endtask

   task automatic check_idle_outputs(input string tag);
      check({tag, " busy"}, busy, 0);
      check({tag, " done"}, done, 0);
      check({tag, " bit_cnt"}, bit_cnt, 0);
      check({tag, " cfg_clk"}, fw_config_clk, 0);
      check({tag, " cfg_in"}, fw_config_in, 0);
      check({tag, " cfg_load"}, fw_config_load, 0);
      check({tag, " rb_wr_en"}, mem_if.rb_wr_en, 0);
      check({tag, " cfg_rd_addr"}, mem_if.cfg_rd_addr, 0);
   endtask

   initial begin
      for (int i = 0; i < CFG_WORDS; i++) cfg_mem[i] = '0;

      // Reset state
      repeat (3) tick();
      rst = 1'b0;
      @(negedge clk);
      check_idle_outputs("reset");
      tick();

      // Basic one-word shift
      cfg_mem[0] = 16'hA5C3;
      launch(16, 6'd2, 16'h1234, 1);
      wait_idle("basic", 200);
      drain("basic", 16);
      check("basic load cycles", load_cycles - load_base, 4);
      check("basic busy cycles", busy_cycles - busy_base, 70);
      check("basic done", done, 1);
      check("basic bit_cnt", bit_cnt, 16);
      check("basic rd_addr", mem_if.cfg_rd_addr, 1);

      // Multi-word with partial last word
      cfg_mem[0] = 16'hFFFF;
      cfg_mem[1] = 16'h0000;
      cfg_mem[2] = 16'h00AB;
      launch(40, 6'd1, 16'hBEEF, 1);
      wait_idle("multi", 400);
      drain("multi", 40);
      check("multi busy cycles", busy_cycles - busy_base, 86);
      check("multi load cycles", load_cycles - load_base, 2);
      check("multi bit_cnt", bit_cnt, 40);
      check("multi rd_addr", mem_if.cfg_rd_addr, 3);

      // HP=0 behaves as HP=1, partial word with nonzero low bits
      cfg_mem[0] = 16'hFFFF;
      cfg_mem[1] = 16'hFFFF;
      launch(20, 6'd0, 16'hFFFF, 1);
      wait_idle("hp0", 400);
      drain("hp0", 20);
      check("hp0 busy cycles", busy_cycles - busy_base, 45);
      check("hp0 load cycles", load_cycles - load_base, 2);
      check("hp0 bit_cnt", bit_cnt, 20);

      // N=0, start held into the DONE cycle
      launch(0, 6'd3, 16'h0000, 2);
      wait_idle("n0", 20);
      drain("n0", 0);
      check("n0 busy cycles", busy_cycles - busy_base, 1);
      check("n0 load cycles", load_cycles - load_base, 0);
      check("n0 done", done, 1);
      check("n0 done rises", done_rises - done_base, 1);
      repeat (3) tick();
      check("n0 stays idle", busy, 0);

      // Start and num_bits change while busy are ignored
      cfg_mem[0] = 16'h3C96;
      launch(16, 6'd1, 16'h5A5A, 1);
      repeat (10) tick();
      num_bits    = 12'd5;
      half_period = 6'd3;
      start       = 1'b1;
      tick();
      start = 1'b0;
      wait_idle("busy_start", 200);
      drain("busy_start", 16);
      check("busy_start busy cycles", busy_cycles - busy_base, 36);
      check("busy_start done rises", done_rises - done_base, 1);
      check("busy_start bit_cnt", bit_cnt, 16);

      // Reset during SHIFT_HI of bit 5
      cfg_mem[0] = 16'hA5C3;
      launch(16, 6'd2, 16'h1234, 1);
      for (int i = 0; i < 500; i++) begin
         if (bit_cnt == 12'd5 && fw_config_clk) break;
         @(negedge clk);
      end
      check("abort reached bit5 hi", {bit_cnt, fw_config_clk}, {12'd5, 1'b1});
      rst = 1'b1;
      tick();
      rst = 1'b0;
      @(negedge clk);
      check_idle_outputs("abort");
      repeat (4) tick();
      check("abort no load", load_cycles - load_base, 0);
      check("abort no rb write", obs_wr.size() - wr_base, 0);
      exp_bits.delete();
      exp_wr.delete();
      launch(16, 6'd2, 16'h1234, 1);
      wait_idle("rerun", 200);
      drain("rerun", 16);
      check("rerun busy cycles", busy_cycles - busy_base, 70);
      check("rerun bit_cnt", bit_cnt, 16);

      // Maximum length: 4095 bits over all 256 words
      for (int i = 0; i < CFG_WORDS; i++) cfg_mem[i] = 16'($urandom);
      launch(4095, 6'd1, 16'hC0DE, 1);
      wait_idle("max", 20000);
      drain("max", 4095);
      check("max busy cycles", busy_cycles - busy_base, 8449);
      check("max bit_cnt", bit_cnt, 4095);
      check("max rd_addr wraps", mem_if.cfg_rd_addr, 0);
      check("max done", done, 1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
